// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: canonical NOP, default reset vector and fetch FSM encoding.
package riscv_pkg;

  localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: synchronous reset, redirect load (wins over increment) and +4 step.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q, pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_pc_i;
    else if (inc_i) pc_d = pc_plus4_o;
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single outstanding imem request, one-entry output slot to decode,
// redirect handling with drain of an in-flight response, and a sticky misaligned-target fault.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;
  logic            misaligned_q, misaligned_d;
  logic            pc_load, pc_inc;
  logic [XLEN-1:0] pc, pc_next4;

  fetch_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_pc_i  (redirect_pc),
    .inc_i      (pc_inc),
    .pc_o       (pc),
    .pc_plus4_o (pc_next4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= RESET_VECTOR;
      instr_q      <= INSTR_NOP;
      instr_pc_q   <= '0;
      pc_plus4_q   <= 32'd4;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // NOTE: every _d signal gets a hold default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    misaligned_d = misaligned_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    if (redirect_valid && state_q != ST_FAULT) begin
      valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d      = ST_FAULT;
        misaligned_d = 1'b1;
      end else begin
        pc_load = 1'b1;
        // An unanswered request keeps its address until the stale response is swallowed.
        if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_rvalid) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
          addr_d  = redirect_pc;
        end
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
          addr_d  = pc;
        end
        ST_FETCH: begin
          if (imem_rvalid) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            pc_plus4_d = pc_next4;
            valid_d    = 1'b1;
            pc_inc     = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            valid_d = 1'b0;
            addr_d  = pc;
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            addr_d  = pc;
            state_d = ST_FETCH;
          end
        end
        ST_FAULT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  end

  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// program-order reference model (next delivered PC = last PC + 4, or the last redirect target).
module tb_fetch_unit;

  logic        clk, rst, redirect_valid, stall, imem_req, imem_rvalid, instr_valid, misaligned;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc, pc_plus4;

  int tests_run    = 0;
  int tests_failed = 0;

  int          mem_lat      = 1;
  bit          mem_rand_lat = 1'b0;
  bit          mem_busy     = 1'b0;
  int          mem_cnt      = 0;
  logic [31:0] mem_addr     = '0;
  int          stable_err   = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hFFB1_0093;
      32'h0000_0004: return 32'h0011_2623;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Instruction memory: answers mem_lat cycles after the request is first seen; flags address changes.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (rst || !imem_req) begin
      mem_busy = 1'b0;
    end else if (!mem_busy) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
    end else begin
      if (imem_addr !== mem_addr) stable_err++;
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_lat = 1; mem_rand_lat = 1'b0;
    step(); step();
    tests_run++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: req=%b valid=%b mis=%b expected 0 0 0", imem_req, instr_valid, misaligned);
    end
    tests_run++;
    if (instr !== 32'h0000_0013 || instr_pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: instr=%h pc=%h pc4=%h addr=%h expected 00000013 0 4 0",
               instr, instr_pc, pc_plus4, imem_addr);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: req=%b expected 0", imem_req);
    end
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok; int cyc;
    wait_valid(10, ok, cyc);
    tests_run++;
    if (!ok || instr !== 32'hFFB1_0093 || instr_pc !== 32'h0 || pc_plus4 !== 32'h4) begin
      tests_failed++;
      $display("FAIL seq_first: ok=%b instr=%h pc=%h pc4=%h expected ffb10093 0 4", ok, instr, instr_pc, pc_plus4);
    end
    step();
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_consumed: valid=%b expected 0", instr_valid);
    end
    wait_valid(10, ok, cyc);
    tests_run++;
    if (!ok || instr !== 32'h0011_2623 || instr_pc !== 32'h4 || pc_plus4 !== 32'h8) begin
      tests_failed++;
      $display("FAIL seq_second: ok=%b instr=%h pc=%h pc4=%h expected 00112623 4 8", ok, instr, instr_pc, pc_plus4);
    end
    tests_run++;
    if (cyc + 1 != 3) begin
      tests_failed++;
      $display("FAIL seq_throughput: %0d cycles between instructions, expected 3", cyc + 1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_instr, held_pc;
    held_instr = instr;
    held_pc    = instr_pc;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc || imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h req=%b expected 1 %h %h 0",
                 i, instr_valid, instr, instr_pc, imem_req, held_instr, held_pc);
      end
    end
    stall = 1'b0;
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL stall_release: req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_outstanding();
    bit ok, found, saw_valid; int cyc;
    mem_lat = 3;
    rst = 1'b1; step(); step(); rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req && imem_addr == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL redir_setup: request for 00000004 not seen, got addr=%h", imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    found = 1'b0; saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) saw_valid = 1'b1;
      if (imem_req && imem_addr !== 32'h4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!found || saw_valid || imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL redir_drain: found=%b dropped_valid_seen=%b addr=%h expected 1 0 00000100",
               found, saw_valid, imem_addr);
    end
    wait_valid(20, ok, cyc);
    tests_run++;
    if (!ok || instr_pc !== 32'h100 || instr !== mem_word(32'h100) || pc_plus4 !== 32'h104) begin
      tests_failed++;
      $display("FAIL redir_target: ok=%b pc=%h instr=%h pc4=%h expected 00000100 %h 00000104",
               ok, instr_pc, instr, pc_plus4, mem_word(32'h100));
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (misaligned !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_enter: mis=%b valid=%b req=%b expected 1 0 0", misaligned, instr_valid, imem_req);
    end
    for (int i = 0; i < 8; i++) begin
      stall          = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom & 32'h0000_0FFC;
      step();
      tests_run++;
      if (misaligned !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL mis_sticky[%0d]: mis=%b valid=%b req=%b expected 1 0 0",
                 i, misaligned, instr_valid, imem_req);
      end
    end
    redirect_valid = 1'b0; stall = 1'b0; mem_lat = 1;
    rst = 1'b1;
    step();
    tests_run++;
    if (misaligned !== 1'b0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_clear: mis=%b req=%b expected 0 0", misaligned, imem_req);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL mis_restart: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok; int cyc;
    wait_valid(10, ok, cyc);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    tests_run++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_redirect_wins: valid=%b req=%b addr=%h expected 0 1 fffffffc",
               instr_valid, imem_req, imem_addr);
    end
    stall = 1'b0;
    wait_valid(10, ok, cyc);
    tests_run++;
    if (!ok || instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || instr !== mem_word(32'hFFFF_FFFC)) begin
      tests_failed++;
      $display("FAIL wrap_fetch: ok=%b pc=%h pc4=%h instr=%h expected fffffffc 00000000 %h",
               ok, instr_pc, pc_plus4, instr, mem_word(32'hFFFF_FFFC));
    end
    step();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_instr, prev_pc, tgt;
    bit prev_valid, prev_stall, prev_redir, redir;
    int deliveries;
    mem_rand_lat = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    exp_pc = 32'h0; deliveries = 0;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; prev_instr = '0; prev_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (instr_valid && !prev_valid) begin
        deliveries++;
        tests_run++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc) || pc_plus4 !== exp_pc + 32'd4) begin
          tests_failed++;
          $display("FAIL rand_deliver[%0d]: pc=%h instr=%h pc4=%h expected %h %h %h",
                   c, instr_pc, instr, pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (prev_valid && prev_stall && !prev_redir) begin
        tests_run++;
        if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
          tests_failed++;
          $display("FAIL rand_stall[%0d]: valid=%b instr=%h pc=%h expected 1 %h %h",
                   c, instr_valid, instr, instr_pc, prev_instr, prev_pc);
        end
      end
      prev_valid = instr_valid; prev_instr = instr; prev_pc = instr_pc;
      stall = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 15) == 0);
      if (redir) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'h0000_0FFC);
        redirect_pc = tgt;
        exp_pc = tgt;
      end
      redirect_valid = redir;
      prev_stall = stall; prev_redir = redir;
    end
    redirect_valid = 1'b0; stall = 1'b0;
    tests_run++;
    if (deliveries < 20) begin
      tests_failed++;
      $display("FAIL rand_progress: %0d deliveries, expected at least 20", deliveries);
    end
  endtask

  initial begin
    imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_misaligned();
    test_wrap();
    test_random();
    tests_run++;
    if (stable_err != 0) begin
      tests_failed++;
      $display("FAIL req_addr_stable: %0d address changes while a request was pending, expected 0", stable_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
